// File: rtl/bcd_pkg.sv
// Shared BCD types and helpers for the multi-digit counter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

    function automatic logic bcd_valid(input bcd_digit_t digit);
        return digit <= BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One packed-BCD digit: combinational +1/-1 with carry/borrow out for chaining.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [3:0] digit_in,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] digit_out,
    output logic       carry,
    output logic       borrow
);

    always_comb begin
        digit_out = digit_in;
        carry     = 1'b0;
        borrow    = 1'b0;
        if (inc) begin
            if (digit_in >= BCD_MAX_DIGIT) begin
                digit_out = 4'd0;
                carry     = 1'b1;
            end else begin
                digit_out = digit_in + 4'd1;
            end
        end else if (dec) begin
            if (digit_in == 4'd0) begin
                digit_out = BCD_MAX_DIGIT;
                borrow    = 1'b1;
            end else begin
                digit_out = digit_in - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_multidigit_counter.sv
// N-digit packed-BCD up/down counter with prescaler, runtime limit, checked load
// and wrap/saturate modes. Outputs are registered; wrap/load_err are one-cycle pulses.
module bcd_multidigit_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [4*DIGITS-1:0]   max_val,
    output logic [4*DIGITS-1:0]   count,
    output logic [7:0]            leds,
    output logic                  wrap,
    output logic                  load_err
);

    localparam int W     = 4 * DIGITS;
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [W-1:0]     eff_max;
    logic [W-1:0]     ripple_val;
    logic [W-1:0]     step_val;
    logic             max_valid;
    logic             load_digits_ok;
    logic             load_ok;
    logic             tick;
    logic             step_wrap;
    logic             ripple_ovf;
    logic [DIGITS:0]  carry;
    logic [DIGITS:0]  borrow;

    always_comb begin
        max_valid      = 1'b1;
        load_digits_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_valid(max_val[4*i +: 4]))  max_valid      = 1'b0;
            if (!bcd_valid(load_val[4*i +: 4])) load_digits_ok = 1'b0;
        end
        eff_max = max_valid ? max_val : {DIGITS{BCD_MAX_DIGIT}};
        load_ok = load_digits_ok && (load_val <= eff_max);
    end

    // Digit 0 is driven by dir; higher digits ripple on carry/borrow.
    assign carry[0]  = dir;
    assign borrow[0] = ~dir;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .digit_in  (count[4*g +: 4]),
            .inc       (carry[g]),
            .dec       (borrow[g]),
            .digit_out (ripple_val[4*g +: 4]),
            .carry     (carry[g+1]),
            .borrow    (borrow[g+1])
        );
    end

    // Top-digit overflow is unreachable while count stays within the limit,
    // but is folded into wrap so a rollover could never go unflagged.
    assign ripple_ovf = carry[DIGITS] | borrow[DIGITS];

    always_comb begin
        step_val  = count;
        step_wrap = 1'b0;
        if (dir) begin
            if (count >= eff_max) begin
                step_val  = SATURATE ? count : '0;
                step_wrap = 1'b1;
            end else begin
                step_val  = ripple_val;
                step_wrap = ripple_ovf;
            end
        end else begin
            if (count == '0) begin
                step_val  = SATURATE ? '0 : eff_max;
                step_wrap = 1'b1;
            end else if (count > eff_max) begin
                step_val  = eff_max;
            end else begin
                step_val  = ripple_val;
                step_wrap = ripple_ovf;
            end
        end
    end

    assign tick = en && (div_cnt == DIV_LAST);

    // A rejected load still blocks the step and holds the prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            div_cnt  <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    count   <= load_val;
                    div_cnt <= '0;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (en) begin
                if (tick) begin
                    div_cnt <= '0;
                    count   <= step_val;
                    wrap    <= step_wrap;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

    assign leds = count[7:0];

endmodule

// File: tb/tb_bcd_multidigit_counter.sv
// Scoreboard bench for bcd_multidigit_counter: three parameter sets share clk/rst_n.
module tb_bcd_multidigit_counter;

    localparam int EW = 20;  // {sel[1:0], count[15:0], wrap, load_err}

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: 2 digits, wrap. Instance B: 2 digits, saturate. Instance C: 4 digits, TICK_DIV=4.
    logic        en_a, dir_a, load_a, wrap_a, err_a;
    logic [7:0]  lv_a, mx_a, cnt_a, leds_a;
    logic        en_b, dir_b, load_b, wrap_b, err_b;
    logic [7:0]  lv_b, mx_b, cnt_b, leds_b;
    logic        en_c, dir_c, load_c, wrap_c, err_c;
    logic [15:0] lv_c, mx_c, cnt_c;
    logic [7:0]  leds_c;

    bcd_multidigit_counter #(.DIGITS(2), .TICK_DIV(1), .SATURATE(1'b0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .dir(dir_a), .load(load_a),
        .load_val(lv_a), .max_val(mx_a), .count(cnt_a), .leds(leds_a),
        .wrap(wrap_a), .load_err(err_a)
    );

    bcd_multidigit_counter #(.DIGITS(2), .TICK_DIV(1), .SATURATE(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .dir(dir_b), .load(load_b),
        .load_val(lv_b), .max_val(mx_b), .count(cnt_b), .leds(leds_b),
        .wrap(wrap_b), .load_err(err_b)
    );

    bcd_multidigit_counter #(.DIGITS(4), .TICK_DIV(4), .SATURATE(1'b0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .en(en_c), .dir(dir_c), .load(load_c),
        .load_val(lv_c), .max_val(mx_c), .count(cnt_c), .leds(leds_c),
        .wrap(wrap_c), .load_err(err_c)
    );

    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Stimulus for one edge; expected state after that edge goes to the scoreboard.
    task automatic drive(input int sel, input logic e, input logic d, input logic ld,
                         input logic [15:0] lv, input logic [15:0] mx,
                         input logic [15:0] ec, input logic ew, input logic eerr);
        logic [1:0] s;
        @(negedge clk);
        s = sel[1:0];
        case (s)
            2'd0: begin en_a = e; dir_a = d; load_a = ld; lv_a = lv[7:0]; mx_a = mx[7:0]; end
            2'd1: begin en_b = e; dir_b = d; load_b = ld; lv_b = lv[7:0]; mx_b = mx[7:0]; end
            default: begin en_c = e; dir_c = d; load_c = ld; lv_c = lv; mx_c = mx; end
        endcase
        exp_q.push_back({s, ec, ew, eerr});
    endtask

    logic [EW-1:0] mon_e;
    logic [15:0]   mon_cnt;
    logic [7:0]    mon_leds;
    logic          mon_wrap, mon_err;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            case (mon_e[19:18])
                2'd0: begin mon_cnt = {8'h00, cnt_a}; mon_leds = leds_a; mon_wrap = wrap_a; mon_err = err_a; end
                2'd1: begin mon_cnt = {8'h00, cnt_b}; mon_leds = leds_b; mon_wrap = wrap_b; mon_err = err_b; end
                default: begin mon_cnt = cnt_c; mon_leds = leds_c; mon_wrap = wrap_c; mon_err = err_c; end
            endcase
            check("count", mon_cnt, mon_e[17:2]);
            check("leds", {8'h00, mon_leds}, {8'h00, mon_e[9:2]});
            check("wrap", {15'h0, mon_wrap}, {15'h0, mon_e[1]});
            check("load_err", {15'h0, mon_err}, {15'h0, mon_e[0]});
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_a_count"}, {8'h00, cnt_a}, 16'h0);
        check({tag, "_a_leds"}, {8'h00, leds_a}, 16'h0);
        check({tag, "_a_flags"}, {14'h0, wrap_a, err_a}, 16'h0);
        check({tag, "_b_count"}, {8'h00, cnt_b}, 16'h0);
        check({tag, "_b_flags"}, {14'h0, wrap_b, err_b}, 16'h0);
        check({tag, "_c_count"}, cnt_c, 16'h0);
        check({tag, "_c_leds"}, {8'h00, leds_c}, 16'h0);
        check({tag, "_c_flags"}, {14'h0, wrap_c, err_c}, 16'h0);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d expected 0", exp_q.size());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        en_a = 0; dir_a = 0; load_a = 0; lv_a = '0; mx_a = '0;
        en_b = 0; dir_b = 0; load_b = 0; lv_b = '0; mx_b = '0;
        en_c = 0; dir_c = 0; load_c = 0; lv_c = '0; mx_c = '0;
        #22;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // A: up 00..99 with max 99, then wrap to 00 and continue.
        for (int k = 1; k <= 99; k++) drive(0, 1, 1, 0, 0, 16'h99, to_bcd(k), 0, 0);
        drive(0, 1, 1, 0, 0, 16'h99, 16'h00, 1, 0);
        drive(0, 1, 1, 0, 0, 16'h99, 16'h01, 0, 0);
        // Loads: accept, bad digit (with a step requested), above max.
        drive(0, 0, 1, 1, 16'h37, 16'h99, 16'h37, 0, 0);
        drive(0, 1, 1, 1, 16'h3A, 16'h99, 16'h37, 0, 1);
        drive(0, 1, 1, 1, 16'h50, 16'h45, 16'h37, 0, 1);
        drive(0, 0, 1, 0, 16'h00, 16'h45, 16'h37, 0, 0);
        // Down from 00 with max 45: wrap to 45 then borrow across 40 -> 39.
        drive(0, 0, 0, 1, 16'h00, 16'h45, 16'h00, 0, 0);
        drive(0, 1, 0, 0, 16'h00, 16'h45, 16'h45, 1, 0);
        for (int k = 44; k >= 38; k--) drive(0, 1, 0, 0, 0, 16'h45, to_bcd(k), 0, 0);
        // Limit lowered below count: down snaps to max, up at max wraps.
        drive(0, 1, 0, 0, 0, 16'h20, 16'h20, 0, 0);
        drive(0, 1, 1, 0, 0, 16'h20, 16'h00, 1, 0);
        // Invalid max digit acts as 99.
        drive(0, 0, 1, 1, 16'h98, 16'hA5, 16'h98, 0, 0);
        drive(0, 1, 1, 0, 0, 16'hA5, 16'h99, 0, 0);
        drive(0, 1, 1, 0, 0, 16'hA5, 16'h00, 1, 0);
        drive(0, 1, 0, 0, 0, 16'hA5, 16'h99, 1, 0);
        drive(0, 0, 0, 0, 0, 16'hA5, 16'h99, 0, 0);

        // B: saturate mode, max 20.
        drive(1, 0, 1, 1, 16'h19, 16'h20, 16'h19, 0, 0);
        drive(1, 1, 1, 0, 0, 16'h20, 16'h20, 0, 0);
        drive(1, 1, 1, 0, 0, 16'h20, 16'h20, 1, 0);
        drive(1, 1, 1, 0, 0, 16'h20, 16'h20, 1, 0);
        drive(1, 0, 0, 1, 16'h00, 16'h20, 16'h00, 0, 0);
        drive(1, 1, 0, 0, 0, 16'h20, 16'h00, 1, 0);
        drive(1, 1, 0, 0, 0, 16'h20, 16'h00, 1, 0);
        drive(1, 1, 1, 0, 0, 16'h20, 16'h01, 0, 0);
        drive(1, 0, 1, 0, 0, 16'h20, 16'h01, 0, 0);

        // C: 4 digits, one step per 4 enabled edges.
        drive(2, 1, 1, 1, 16'h0999, 16'h9999, 16'h0999, 0, 0);
        repeat (3) drive(2, 1, 1, 0, 0, 16'h9999, 16'h0999, 0, 0);
        drive(2, 1, 1, 0, 0, 16'h9999, 16'h1000, 0, 0);
        repeat (3) drive(2, 1, 0, 0, 0, 16'h9999, 16'h1000, 0, 0);
        drive(2, 1, 0, 0, 0, 16'h9999, 16'h0999, 0, 0);
        // en dropped for 3 cycles mid-prescale delays the step by 3.
        repeat (2) drive(2, 1, 0, 0, 0, 16'h9999, 16'h0999, 0, 0);
        repeat (3) drive(2, 0, 0, 0, 0, 16'h9999, 16'h0999, 0, 0);
        drive(2, 1, 0, 0, 0, 16'h9999, 16'h0999, 0, 0);
        drive(2, 1, 0, 0, 0, 16'h9999, 16'h0998, 0, 0);
        // Load on the step edge wins and restarts the prescaler.
        repeat (3) drive(2, 1, 1, 0, 0, 16'h9999, 16'h0998, 0, 0);
        drive(2, 1, 1, 1, 16'h1234, 16'h9999, 16'h1234, 0, 0);
        repeat (3) drive(2, 1, 1, 0, 0, 16'h9999, 16'h1234, 0, 0);
        drive(2, 1, 1, 0, 0, 16'h9999, 16'h1235, 0, 0);
        // Rejected load on the step edge discards the step.
        repeat (3) drive(2, 1, 1, 0, 0, 16'h9999, 16'h1235, 0, 0);
        drive(2, 1, 1, 1, 16'h12A4, 16'h9999, 16'h1235, 0, 1);
        drive(2, 0, 1, 0, 0, 16'h9999, 16'h1235, 0, 0);

        // Asynchronous reset between edges clears every instance at once.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) drive(2, 1, 1, 0, 0, 16'h9999, 16'h0000, 0, 0);
        drive(2, 1, 1, 0, 0, 16'h9999, 16'h0001, 0, 0);
        drive(2, 0, 1, 0, 0, 16'h9999, 16'h0001, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_multidigit_counter.md
# bcd_multidigit_counter

Parametrised N-digit packed-BCD up/down counter, successor to the two-digit BCD up/down counter. Adds a digit-count parameter, runtime upper limit, synchronous load with validity checking, a clock-enable prescaler, and wrap or saturate modes. Drives the lab's seven-segment and LED display path through `count` and `leds`.

## Interface
- `DIGITS`, 4: number of BCD digits, ≥2; count width is 4*DIGITS.
- `TICK_DIV`, 1: enabled clocks per count step, ≥1; 1 = step every enabled cycle.
- `SATURATE`, 0: 0 = wrap at limits; 1 = hold at limits.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  count enable; prescaler and counter hold while low.
- `dir`  in  1  1 = count up, 0 = count down.
- `load`  in  1  synchronous load request, one-cycle sample.
- `load_val`  in  4*DIGITS  packed BCD value to load, digit 0 in [3:0].
- `max_val`  in  4*DIGITS  packed BCD upper limit (inclusive).
- `count`  out  4*DIGITS  current packed BCD value.
- `leds`  out  8  `count[7:0]`, i.e. {tens, units}.
- `wrap`  out  1  one-cycle pulse when a step wraps or hits a limit.
- `load_err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- Priority per edge: reset > load > step > hold.
- Packed BCD compares as unsigned binary, so limit checks use plain vector comparison.
- `max_val` with any digit >9 is treated as all-9s.
- Load: accepted if every `load_val` digit ≤9 and `load_val` ≤ effective max. Then `count` ← `load_val` and the prescaler clears. Otherwise `count` is unchanged and `load_err` pulses. A load never asserts `wrap`.
- Prescaler: `div_cnt` runs 0..TICK_DIV-1 and advances only when `en`=1 and `load`=0. A step occurs on an enabled cycle with `div_cnt`=TICK_DIV-1, after which `div_cnt` returns to 0.
- Up step:
  - if `count` ≥ max, then `count` ← 0 (SATURATE=0) or holds (SATURATE=1), and `wrap` pulses;
  - else BCD +1, with ripple carry: a digit at 9 becomes 0 and carries.
- Down step:
  - if `count`=0, then `count` ← max (SATURATE=0) or holds at 0, and `wrap` pulses;
  - else, if `count` > max (max lowered at runtime), `count` ← max;
  - else BCD −1, with ripple borrow: a digit at 0 becomes 9 and borrows.
- `dir` is sampled on the step edge only; changing it mid-prescale is legal.

## Timing
- Reset values: `count`=0, `leds`=0, `wrap`=0, `load_err`=0, `div_cnt`=0.
- All outputs are registered:
  - `count` changes on the step or load edge;
  - `wrap` and `load_err` go high for exactly the cycle following that edge.
- Step latency from `en` rising is TICK_DIV edges.
- Reset asserted mid-prescale clears everything immediately. First step comes TICK_DIV enabled edges after release.
- `load` and step on the same edge: load wins and the step is discarded, including on a rejected load.

## Structure
- Package `bcd_pkg`: BCD digit typedef (4-bit), `BCD_MAX_DIGIT`=4'd9, helper function `bcd_valid(digit)`.
- Sub-module `bcd_digit`: one digit with `inc`/`dec` request in, next value out, carry/borrow out. Top generates DIGITS instances chained on carry/borrow.
- Top holds the prescaler, limit/validity comparison, load logic and output registers.

## Test plan
- DIGITS=2, TICK_DIV=1, max=99, dir=1, count 0 → 99 then next edge → 00 with `wrap`=1 for one cycle; `leds`=8'h99 before the wrap.
- DIGITS=2, dir=0 from 00 with max=8'h45 → 45, `wrap` pulse, then 44, 43 … with the 40 → 39 borrow correct.
- Load 8'h37 (max 99) → `count`=37 next cycle, no flags. Load 8'h3A → `load_err` pulse, count unchanged. Load 8'h50 with max=8'h45 → `load_err`.
- SATURATE=1, up at `count`=max=8'h20 → holds 20 with `wrap` pulse each step. Down at 0 → holds 0.
- TICK_DIV=4, en=1 → one step per 4 clocks. Drop en for 3 cycles mid-prescale → the step is delayed by exactly 3 cycles.
- DIGITS=4 ripple: up from 16'h0999 → 16'h1000. Down from 16'h1000 → 16'h0999. `rst_n` low mid-run → all outputs 0 asynchronously.
